zx_dac_bank: RTL
================

# zx_dac_bank

Parametrised multi-channel 1-bit DAC bank for the multisound CPLD. It replaces the fixed 4-channel PWM/volume DAC with NCH channels, each carrying a sample register and a volume register. Volume changes can be applied immediately or ramped to avoid zipper noise, and each channel drives a first-order sigma-delta output pin. Two sample-write ports feed it: the host Covox/Soundrive port (A) and the GS Z80 DAC port (B). Volume writes come from the GS volume ports.

## Interface
Parameters
- NCH, 4: channel count, 1..16
- DW, 8: sample width, offset-binary, 0x80 = midscale at DW=8
- VW, 6: volume width
- RAMP_DIV, 256: clk32 cycles per volume ramp step, ≥2
- SIGNED_IN, 0: 1 = port data is two's complement; the MSB is inverted on capture

Ports (CW = max(1, clog2(NCH)))
- clk32  in  1  sole clock, 32 MHz
- rst  in  1  reset, synchronous, active-high
- a_wr  in  1  port A sample write strobe, one cycle
- a_ch  in  CW  port A channel index
- a_data  in  DW  port A sample
- b_wr  in  1  port B sample write strobe
- b_ch  in  CW  port B channel index
- b_data  in  DW  port B sample
- vol_wr  in  1  volume write strobe
- vol_ch  in  CW  volume channel index
- vol_data  in  VW  target volume
- vol_ramp  in  1  sampled with vol_wr: 1 = ramp, 0 = immediate
- dac_out  out  NCH  sigma-delta bitstream per channel
- vol_busy  out  NCH  per channel: ramp in progress (vol_eff ≠ vol_tgt)

## Operation
- Sample capture
  - On a_wr or b_wr, sample[ch] ← data (MSB inverted when SIGNED_IN=1).
  - If both ports write the same channel in the same cycle, port A wins.
  - If they write different channels in the same cycle, both are captured.
  - A channel index ≥ NCH is ignored on every port.
- Volume control
  - Each channel holds vol_tgt and vol_eff.
  - Immediate write (vol_ramp=0): vol_tgt ← vol_eff ← vol_data.
  - Ramped write (vol_ramp=1): vol_tgt ← vol_data, and vol_eff is unchanged.
- Ramp
  - A free-running tick counter counts 0..RAMP_DIV-1. The tick fires when the counter wraps.
  - On each tick, every channel with vol_eff ≠ vol_tgt steps vol_eff by ±1 toward vol_tgt.
  - A volume write on a tick cycle takes precedence over the step for that channel.
  - A new target written mid-ramp redirects the ramp starting from the current vol_eff.
- Gain
  - g = vol_eff, except g = 2^VW (unity) when vol_eff is all ones.
  - level = (sample × g) >> VW, truncated to DW bits.
  - The product is computed in a DW+VW+1-bit intermediate.
- Modulator
  - acc is DW+1 bits: acc ← {0, acc[DW-1:0]} + level.
  - dac_out[i] = acc[DW], taken directly from the register.
  - Over 2^DW cycles, the ones count equals level exactly.
  - vol_eff = 0 gives constant 0.

## Timing
- Reset: all samples = 0, vol_tgt = vol_eff = 0, acc = 0, tick counter = 0. Outputs: dac_out = 0, vol_busy = 0.
- Write-to-output latency:
  - A write on edge N updates sample at N.
  - The level register updates at N+1.
  - acc (and dac_out) reflects the new level at N+2.
- Volume latency:
  - An immediate write affects level one edge later than the write.
  - vol_busy rises on the edge after a ramped write with vol_data ≠ vol_eff.
  - vol_busy falls on the edge at which vol_eff reaches vol_tgt.
- Ramp duration is |Δ| × RAMP_DIV cycles ±RAMP_DIV, because of tick phase.
- Reset asserted mid-ramp or mid-write aborts the operation; all state returns to reset values on the next edge.
- No back-pressure: every strobe is accepted in its cycle.

## Structure
- Shared package zx_ms_pkg holds:
  - the clog2-based CW function
  - the unity-gain helper, vol_unity(VW)
  - the port-priority constant (A over B)
- Sub-module zx_sdm_chan is instantiated NCH times. It owns sample, vol_tgt/vol_eff, the gain multiply, the level register and acc.
- The top level owns:
  - the write decode and priority
  - the shared ramp tick counter
- The tick reaches every channel as a one-cycle enable.

## Test plan
- Reset: assert rst for 2 cycles → dac_out = 0 and vol_busy = 0 on every channel; 300 further cycles produce no ones.
- Full scale: port A writes ch0 = 0xFF, immediate vol = 63 → exactly 255 ones in any 256-cycle window after latency; write ch0 = 0x80 → exactly 128 ones.
- Gain: ch1 sample 0x80, vol 32 → level 64 → 64 ones per 256 cycles; vol 0 → constant 0.
- Ramp (RAMP_DIV=4): ch2 vol 0 → ramped write to 63 → vol_busy high for 252±4 cycles, vol_eff monotonic; write target 10 mid-ramp → vol_eff reverses toward 10.
- Collision: A writes ch3 = 0x11 and B writes ch3 = 0x22 in the same cycle → sample 0x11; A on ch0 and B on ch1 in the same cycle → both captured.
- NCH=3: a_ch=3 write → no channel changes; SIGNED_IN=1 with data 0x00 → sample 0x80.

Source files
------------

// File: rtl/zx_ms_pkg.sv
// Shared definitions for the multisound DAC bank: index-width helper, unity-gain
// helper and the sample-port priority.
package zx_ms_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Port A (host Covox/Soundrive) wins a same-channel collision with port B.
  localparam port_e PORT_PRIO = PORT_A;

  function automatic int cw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int vol_unity(input int vw);
    return 1 << vw;
  endfunction

endpackage

// File: rtl/zx_sdm_chan.sv
// One DAC channel: sample and volume registers, volume ramp stepping, gain
// multiply into a registered level, and a first-order sigma-delta accumulator.
module zx_sdm_chan
  import zx_ms_pkg::*;
#(
  parameter int DW = 8,
  parameter int VW = 6
) (
  input  logic          clk32,
  input  logic          rst,
  input  logic          smp_wr,
  input  logic [DW-1:0] smp_data,
  input  logic          vol_wr,
  input  logic [VW-1:0] vol_data,
  input  logic          vol_ramp,
  input  logic          tick,
  output logic          dac_out,
  output logic          vol_busy
);

  localparam logic [VW:0] G_UNITY = (VW+1)'(vol_unity(VW));

  logic [DW-1:0] sample_q, sample_d;
  logic [VW-1:0] vol_tgt_q, vol_tgt_d;
  logic [VW-1:0] vol_eff_q, vol_eff_d;
  logic [DW-1:0] level_q, level_d;
  logic [DW:0]   acc_q, acc_d;
  logic [VW:0]   gain;
  logic [DW+VW:0] prod;

  always_comb begin
    sample_d  = sample_q;
    vol_tgt_d = vol_tgt_q;
    vol_eff_d = vol_eff_q;
    if (smp_wr) sample_d = smp_data;
    // A write on a tick cycle overrides that cycle's ramp step.
    if (vol_wr) begin
      vol_tgt_d = vol_data;
      if (!vol_ramp) vol_eff_d = vol_data;
    end else if (tick && (vol_eff_q != vol_tgt_q)) begin
      if (vol_eff_q < vol_tgt_q) vol_eff_d = vol_eff_q + 1'b1;
      else                       vol_eff_d = vol_eff_q - 1'b1;
    end
  end

  // Gain stage: all-ones volume maps to exact unity so full scale stays full scale.
  always_comb begin
    gain    = (&vol_eff_q) ? G_UNITY : {1'b0, vol_eff_q};
    prod    = {{(VW+1){1'b0}}, sample_q} * {{DW{1'b0}}, gain};
    level_d = prod[VW +: DW];
  end

  // Modulator stage: the carry out of the DW-bit accumulator is the bitstream.
  always_comb begin
    acc_d = {1'b0, acc_q[DW-1:0]} + {1'b0, level_q};
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      sample_q  <= '0;
      vol_tgt_q <= '0;
      vol_eff_q <= '0;
      level_q   <= '0;
      acc_q     <= '0;
    end else begin
      sample_q  <= sample_d;
      vol_tgt_q <= vol_tgt_d;
      vol_eff_q <= vol_eff_d;
      level_q   <= level_d;
      acc_q     <= acc_d;
    end
  end

  assign dac_out  = acc_q[DW];
  assign vol_busy = (vol_eff_q != vol_tgt_q);

endmodule

// File: rtl/zx_dac_bank.sv
// Multi-channel 1-bit DAC bank: decodes the two sample ports and the volume port
// onto NCH sigma-delta channels and distributes the shared volume-ramp tick.
module zx_dac_bank
  import zx_ms_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DW        = 8,
  parameter int VW        = 6,
  parameter int RAMP_DIV  = 256,
  parameter int SIGNED_IN = 0,
  localparam int CW       = cw_f(NCH)
) (
  input  logic           clk32,
  input  logic           rst,
  input  logic           a_wr,
  input  logic [CW-1:0]  a_ch,
  input  logic [DW-1:0]  a_data,
  input  logic           b_wr,
  input  logic [CW-1:0]  b_ch,
  input  logic [DW-1:0]  b_data,
  input  logic           vol_wr,
  input  logic [CW-1:0]  vol_ch,
  input  logic [VW-1:0]  vol_data,
  input  logic           vol_ramp,
  output logic [NCH-1:0] dac_out,
  output logic [NCH-1:0] vol_busy
);

  localparam int TW = $clog2(RAMP_DIV);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [DW-1:0] a_cap, b_cap;

  // Two's-complement ports become offset-binary by flipping the MSB.
  always_comb begin
    a_cap = a_data;
    b_cap = b_data;
    if (SIGNED_IN != 0) begin
      a_cap[DW-1] = ~a_data[DW-1];
      b_cap[DW-1] = ~b_data[DW-1];
    end
  end

  always_comb begin
    tick       = (tick_cnt_q == TW'(RAMP_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk32) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  // Indices >= NCH match no channel and are therefore dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic a_hit, b_hit, pick_a, v_hit;

    assign a_hit  = a_wr && (a_ch == CW'(i));
    assign b_hit  = b_wr && (b_ch == CW'(i));
    assign v_hit  = vol_wr && (vol_ch == CW'(i));
    assign pick_a = a_hit && ((PORT_PRIO == PORT_A) || !b_hit);

    zx_sdm_chan #(
      .DW(DW),
      .VW(VW)
    ) u_ch (
      .clk32   (clk32),
      .rst     (rst),
      .smp_wr  (a_hit || b_hit),
      .smp_data(pick_a ? a_cap : b_cap),
      .vol_wr  (v_hit),
      .vol_data(vol_data),
      .vol_ramp(vol_ramp),
      .tick    (tick),
      .dac_out (dac_out[i]),
      .vol_busy(vol_busy[i])
    );
  end

endmodule
